// File: rtl/nobl_arb_pkg.sv
// Shared constants and helpers for the SRAM port arbiter.
// The optional per-requester grant counters are enabled with NOBL_ARB_PERF_CNT_EN.
package nobl_arb_pkg;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned MAX_OUT_DEF = 6;

  // A requester ID needs at least one bit, even when there is only one requester.
  function automatic int unsigned tag_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/nobl_arb_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per read still waiting for its data.
module nobl_arb_tag_fifo
  import nobl_arb_pkg::*;
#(
  parameter int unsigned DEPTH_N = MAX_OUT_DEF,
  parameter int unsigned TAG_W   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push,
  input  logic [TAG_W-1:0]               i_tag,
  input  logic                           i_pop,
  output logic [TAG_W-1:0]               o_tag,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [$clog2(DEPTH_N+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(DEPTH_N + 1);
  localparam int unsigned PW = (DEPTH_N > 1) ? $clog2(DEPTH_N) : 1;

  logic [TAG_W-1:0] r_mem [DEPTH_N];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH_N - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | i_pop);
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH_N));
  assign o_count = r_count;
  assign o_tag   = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= next_ptr(r_wr);
      if (w_pop)  r_rd <= next_ptr(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/nobl_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NREQ requesters, with in-order read return.
// Define NOBL_ARB_PERF_CNT_EN to build saturating per-requester grant counters.
module nobl_arbiter
  import nobl_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned DEPTH   = 19,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*DEPTH-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         req_grant,
  output logic [WIDTH-1:0]        rd_data,
  output logic [NREQ-1:0]         rd_valid,
  output logic [DEPTH-1:0]        address,
  output logic [WIDTH-1:0]        data_out,
  output logic                    write,
  output logic                    enable,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    data_in_valid,
  output logic                    err_orphan,
  output logic [NREQ*CNT_W-1:0]   grant_cnt
);

  localparam int unsigned TW = tag_w(NREQ);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [TW-1:0] r_ptr;
  logic [OW-1:0] r_quiet;
  logic          r_err;

  logic          w_gnt_found;
  logic [TW-1:0] w_gnt_idx;
  logic [TW:0]   w_idx;
  logic          w_rd_block;
  logic          w_push;
  logic          w_ret_live;
  logic          w_ret_ok;
  logic          w_orphan;
  logic [TW-1:0] w_pop_tag;
  logic          w_empty;
  logic          w_full;
  logic [OW-1:0] w_count;

  assign w_rd_block = w_full | (w_count == OW'(MAX_OUT));

  // Search starts at r_ptr and wraps; reads are skipped while the tag FIFO is full.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (TW+1)'(k);
      if (w_idx >= (TW+1)'(NREQ)) w_idx = w_idx - (TW+1)'(NREQ);
      if (!w_gnt_found && req_valid[w_idx[TW-1:0]] &&
          (req_write[w_idx[TW-1:0]] || !w_rd_block)) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_idx[TW-1:0];
      end
    end
    if (rst) w_gnt_found = 1'b0;
  end

  always_comb begin
    req_grant = '0;
    address   = '0;
    data_out  = '0;
    write     = 1'b0;
    enable    = w_gnt_found;
    if (w_gnt_found) req_grant[w_gnt_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_grant[i]) begin
        write    = req_write[i];
        address  = req_addr[i*DEPTH +: DEPTH];
        data_out = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_push = w_gnt_found & ~req_write[w_gnt_idx];

  // Returns in the first MAX_OUT cycles after reset belong to reads dropped by the reset.
  assign w_ret_live = data_in_valid & ~rst & (r_quiet == '0);
  assign w_ret_ok   = w_ret_live & ~w_empty;
  assign w_orphan   = w_ret_live & w_empty;

  always_comb begin
    rd_valid = '0;
    if (w_ret_ok) rd_valid[w_pop_tag] = 1'b1;
  end

  assign rd_data    = data_in;
  assign err_orphan = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_quiet <= OW'(MAX_OUT);
      r_err   <= 1'b0;
    end else begin
      if (w_gnt_found) r_ptr <= (w_gnt_idx == TW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      if (r_quiet != '0) r_quiet <= r_quiet - 1'b1;
      if (w_orphan) r_err <= 1'b1;
    end
  end

  nobl_arb_tag_fifo #(
    .DEPTH_N (MAX_OUT),
    .TAG_W   (TW)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_tag   (w_gnt_idx),
    .i_pop   (w_ret_ok),
    .o_tag   (w_pop_tag),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

`ifdef NOBL_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] r_cnt [NREQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) r_cnt[i] <= '0;
      else if (req_grant[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_nobl_arbiter.sv
// Directed and random checks of nobl_arbiter against a queue-based reference model.
module tb_nobl_arbiter;

  localparam int NREQ = 2, WIDTH = 18, DEPTH = 19, MAX_OUT = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_write, req_grant, rd_valid;
  logic [NREQ*DEPTH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0]      rd_data, data_out, data_in;
  logic [DEPTH-1:0]      address;
  logic                  write, enable, data_in_valid, err_orphan;
  logic [NREQ*16-1:0]    grant_cnt;

  nobl_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant),
    .rd_data(rd_data), .rd_valid(rd_valid), .address(address), .data_out(data_out),
    .write(write), .enable(enable), .data_in(data_in), .data_in_valid(data_in_valid),
    .err_orphan(err_orphan), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model state
  int  m_ptr;
  int  m_q[$];
  bit  m_err;
  int  m_quiet;
  int  m_cnt[NREQ];
  bit  m_known = 0;

  int              e_gi;
  logic [NREQ-1:0] e_rdv;
  bit              e_orphan;
  logic [NREQ-1:0] s_grant, s_rdv;
  logic [WIDTH-1:0] s_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [NREQ*16-1:0] e_cnt;
    @(negedge clk);
    e_gi = -1;
    if (!rst)
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (e_gi < 0 && req_valid[i] && (req_write[i] || m_q.size() < MAX_OUT)) e_gi = i;
      end
    e_rdv = '0;
    e_orphan = 0;
    if (!rst && data_in_valid && m_quiet == 0) begin
      if (m_q.size() > 0) e_rdv[m_q[0]] = 1'b1;
      else e_orphan = 1;
    end
    s_grant = req_grant;
    s_rdv   = rd_valid;
    s_rdata = rd_data;
    chk("grant", req_grant, (e_gi >= 0) ? (64'd1 << e_gi) : 64'd0);
    chk("enable", enable, (e_gi >= 0) ? 64'd1 : 64'd0);
    chk("write", write, (e_gi >= 0) ? 64'(req_write[e_gi]) : 64'd0);
    if (e_gi >= 0) begin
      chk("address", address, req_addr[e_gi*DEPTH +: DEPTH]);
      chk("data_out", data_out, req_wdata[e_gi*WIDTH +: WIDTH]);
    end
    chk("rd_valid", rd_valid, e_rdv);
    if (e_rdv != 0) chk("rd_data", rd_data, data_in);
    if (m_known) begin
      chk("err_orphan", err_orphan, m_err);
      for (int i = 0; i < NREQ; i++) begin
`ifdef NOBL_ARB_PERF_CNT_EN
        e_cnt[i*16 +: 16] = 16'(m_cnt[i]);
`else
        e_cnt[i*16 +: 16] = 16'd0;
`endif
      end
      chk("grant_cnt", grant_cnt, e_cnt);
    end
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_q.delete(); m_err = 0; m_quiet = MAX_OUT; m_known = 1;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else begin
      if (e_rdv != 0) void'(m_q.pop_front());
      if (e_gi >= 0) begin
        if (!req_write[e_gi]) m_q.push_back(e_gi);
        m_ptr = (e_gi + 1) % NREQ;
        if (m_cnt[e_gi] < 65535) m_cnt[e_gi]++;
      end
      if (e_orphan) m_err = 1;
      if (m_quiet > 0) m_quiet--;
    end
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit w);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*DEPTH +: DEPTH]  = DEPTH'($urandom);
    req_wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic idle();
    req_valid = '0; req_write = '0; data_in_valid = 1'b0;
  endtask

  task automatic ret(input logic [WIDTH-1:0] d);
    data_in = d; data_in_valid = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] dat[4];
    dat[0] = 18'h0A0A; dat[1] = 18'h0B0B; dat[2] = 18'h0C0C; dat[3] = 18'h0D0D;
    idle();
    data_in = '0;
    rst = 1'b1;
    set_req(0, 1, 1); set_req(1, 1, 1);
    repeat (2) step();
    chk("reset_grant", s_grant, 0);
    rst = 1'b0;
    chk("reset_err", err_orphan, 0);

    // Two continuous writers alternate, pointer starts at requester 0
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1, 1); set_req(1, 1, 1);
      step();
      chk("alt_grant", s_grant, (k % 2) ? 2'b10 : 2'b01);
    end

    // Six reads fill the tag FIFO; the seventh read waits, a write from 1 goes
    idle();
    for (int k = 0; k < 6; k++) begin set_req(0, 1, 0); step(); chk("fill_grant", s_grant, 2'b01); end
    set_req(0, 1, 0); set_req(1, 1, 1);
    step();
    chk("full_wr_bypass", s_grant, 2'b10);
    idle(); set_req(0, 1, 0);
    step();
    chk("full_rd_blocked", s_grant, 2'b00);
    idle();
    for (int k = 0; k < 6; k++) begin ret(WIDTH'($urandom)); step(); chk("drain_rdv", s_rdv, 2'b01); end

    // Interleaved reads with returns four cycles later
    idle(); set_req(0, 1, 0); step();
    idle(); set_req(1, 1, 0); step();
    idle(); set_req(1, 1, 0); step();
    idle(); set_req(0, 1, 0); step();
    for (int k = 0; k < 4; k++) begin
      idle(); ret(dat[k]); step();
      chk("inter_rdv", s_rdv, (k == 1 || k == 2) ? 2'b10 : 2'b01);
      chk("inter_rdata", s_rdata, dat[k]);
    end

    // Push and pop together with 3 outstanding keeps the count at 3
    idle(); set_req(0, 1, 0); step();
    idle(); set_req(1, 1, 0); step();
    idle(); set_req(0, 1, 0); step();
    idle(); set_req(1, 1, 0); ret(18'h0E0E); step();
    chk("pp_rdv", s_rdv, 2'b01);
    chk("pp_grant", s_grant, 2'b10);
    for (int k = 0; k < 4; k++) begin
      idle(); set_req(0, 1, 0); step();
      chk("pp_refill", s_grant, (k < 3) ? 2'b01 : 2'b00);
    end
    idle(); ret(18'h1111); step();
    chk("pp_order", s_rdv, 2'b10);
    for (int k = 0; k < 5; k++) begin idle(); ret(WIDTH'($urandom)); step(); end

    // Orphan return sets a sticky error that only reset clears
    idle(); rst = 1'b1; step(); rst = 1'b0;
    repeat (10) step();
    ret(18'h2222); step();
    chk("orphan_rdv", s_rdv, 2'b00);
    idle();
    for (int k = 0; k < 3; k++) begin step(); chk("orphan_sticky", err_orphan, 1); end
    rst = 1'b1; step(); rst = 1'b0;
    chk("orphan_clear", err_orphan, 0);

    // Reset with reads in flight; stale returns are ignored
    repeat (6) step();
    for (int k = 0; k < 4; k++) begin idle(); set_req(0, 1, 0); step(); end
    idle(); rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin ret(WIDTH'($urandom)); step(); chk("stale_rdv", s_rdv, 2'b00); end
    idle(); step();
    chk("stale_err", err_orphan, 0);
    repeat (2) step();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, 1), $urandom_range(0, 1));
      data_in = WIDTH'($urandom);
      data_in_valid = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

`ifdef NOBL_ARB_PERF_CNT_EN
    idle(); rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 70000; k++) begin set_req(0, 1, 1); step(); end
    chk("cnt_saturate", grant_cnt[15:0], 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
